// File: rtl/cpu_pkg.sv
// Shared MIPS core definitions: access sizes, byte lanes, DM defaults.
// Also hosts the store byte-merge helper used by the data memory.
package cpu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  localparam int DM_DEPTH_WORDS = 1024;

  function automatic logic [31:0] dm_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [1:0]  sz,
    input logic [1:0]  lo
  );
    logic [31:0] w;
    w = old;
    unique case (sz)
      SZ_WORD: w = wd;
      SZ_HALF: begin
        if (lo[1]) w[31:16] = wd[15:0];
        else       w[15:0]  = wd[15:0];
      end
      SZ_BYTE: begin
        unique case (lo)
          LANE_B0: w[7:0]   = wd[7:0];
          LANE_B1: w[15:8]  = wd[7:0];
          LANE_B2: w[23:16] = wd[7:0];
          LANE_B3: w[31:24] = wd[7:0];
        endcase
      end
      SZ_RSVD: w = old;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/dm_stage_if.sv
// M-stage data-memory port: access request, load result, error flags
// and the registered write-log seen by the trace monitor.
interface dm_stage_if;

  logic        mem_en;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        align_err;
  logic        range_err;
  logic        wlog_valid;
  logic [31:0] wlog_addr;
  logic [31:0] wlog_data;

  modport master (
    output mem_en, mem_we, mem_size, mem_unsigned,
    output addr, wdata,
    input  rdata, align_err, range_err,
    input  wlog_valid, wlog_addr, wlog_data
  );

  modport slave (
    input  mem_en, mem_we, mem_size, mem_unsigned,
    input  addr, wdata,
    output rdata, align_err, range_err,
    output wlog_valid, wlog_addr, wlog_data
  );

endinterface

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension for a 32-bit memory word.
// Shared by the DM path and any later bridge/MMIO load path.
module dm_load_ext
  import cpu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        bs;
  logic        hs;

  always_comb begin
    b = 8'h00;
    unique case (addr_lo)
      LANE_B0: b = word[7:0];
      LANE_B1: b = word[15:8];
      LANE_B2: b = word[23:16];
      LANE_B3: b = word[31:24];
    endcase
    h  = addr_lo[1] ? word[31:16] : word[15:0];
    bs = ~uns & b[7];
    hs = ~uns & h[15];
    data = 32'h0;
    unique case (size)
      SZ_BYTE: data = {{24{bs}}, b};
      SZ_HALF: data = {{16{hs}}, h};
      SZ_WORD: data = word;
      SZ_RSVD: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dm_stage.sv
// M-stage data memory: byte-merging stores, extending loads,
// alignment/range flags and a one-cycle registered write-log.
module dm_stage
  import cpu_pkg::*;
#(
  parameter int          DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    reset,
  dm_stage_if.slave bus
);

  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS) << 2;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] offset;
  logic [IW-1:0] idx;
  logic [31:0] cur;
  logic [31:0] merged;
  logic [31:0] ext;
  logic        mis;
  logic        align_err;
  logic        range_err;
  logic        commit;
  logic        ld_ok;

  logic        wlog_valid;
  logic [31:0] wlog_addr;
  logic [31:0] wlog_data;

  assign offset = bus.addr - BASE_ADDR;
  assign idx    = offset[IW+1:2];

  always_comb begin
    mis = 1'b0;
    unique case (bus.mem_size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = bus.addr[0];
      SZ_WORD: mis = |bus.addr[1:0];
      SZ_RSVD: mis = 1'b1;
    endcase
  end

  assign align_err = bus.mem_en & mis;
  assign range_err = bus.mem_en & (offset >= LIMIT);

  assign commit = bus.mem_en & bus.mem_we & ~align_err & ~range_err;
  assign ld_ok  = bus.mem_en & ~bus.mem_we & ~align_err & ~range_err;

  // Read is asynchronous so a load right after a store sees new data.
  assign cur    = mem[idx];
  assign merged = dm_merge(cur, bus.wdata, bus.mem_size, bus.addr[1:0]);

  dm_load_ext u_ext (
    .word    (cur),
    .addr_lo (bus.addr[1:0]),
    .size    (bus.mem_size),
    .uns     (bus.mem_unsigned),
    .data    (ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
      wlog_valid <= 1'b0;
      wlog_addr  <= 32'h0;
      wlog_data  <= 32'h0;
    end else begin
      wlog_valid <= commit;
      if (commit) begin
        mem[idx]  <= merged;
        wlog_addr <= BASE_ADDR + {offset[31:2], 2'b00};
        wlog_data <= merged;
      end
    end
  end

  assign bus.rdata      = ld_ok ? ext : 32'h0;
  assign bus.align_err  = align_err;
  assign bus.range_err  = range_err;
  assign bus.wlog_valid = wlog_valid;
  assign bus.wlog_addr  = wlog_addr;
  assign bus.wlog_data  = wlog_data;

endmodule

// File: doc/dm_stage.md
Name: dm_stage

Overview:
- Data-memory block of the M stage in the 5-stage pipelined MIPS core.
- Sits directly upstream of the M/W pipeline register and produces its load-data input (the DM_W path).
- Performs sw/sh/sb stores with little-endian byte merging, and lw/lh/lhu/lb/lbu loads with extension.
- Flags misaligned and out-of-range accesses, and emits a registered one-cycle write-log for the trace monitor.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (4 KB).
- BASE_ADDR, 32'h0000_0000, byte address that maps to word 0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- mem_en  in  1  the M-stage instruction is a load or store.
- mem_we  in  1  1 = store, 0 = load; ignored when mem_en=0.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- mem_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  32  byte address, already computed by the ALU.
- wdata  in  32  store data, right-aligned (rt value).
- rdata  out  32  extended load data; combinational.
- align_err  out  1  misaligned access or reserved size; combinational.
- range_err  out  1  address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS); combinational.
- wlog_valid  out  1  registered pulse, one cycle after each committed store.
- wlog_addr  out  32  registered word-aligned byte address of the committed store.
- wlog_data  out  32  registered full word after the merge.

Behaviour:
- Address mapping:
  - offset = addr - BASE_ADDR (32-bit wrap).
  - word index = offset[31:2].
  - range_err = mem_en & (offset >= 4*DEPTH_WORDS).
- Alignment:
  - align_err = mem_en & (size=10 & addr[1:0]!=0 | size=01 & addr[0] | size=11).
- Store commit:
  - A store commits at the rising edge when mem_en & mem_we & !align_err & !range_err.
  - Word: replaces the whole word.
  - Half: wdata[15:0] goes to lane addr[1] (0 → bits 15:0, 1 → bits 31:16).
  - Byte: wdata[7:0] goes to lane addr[1:0].
  - All other bits of the word are preserved.
- Suppressed store: a store with either error flag leaves the array untouched and does not pulse wlog_valid.
- Loads:
  - Asynchronous read of the current array contents.
  - Select the lane by addr and size, then sign- or zero-extend per mem_unsigned.
  - Word loads ignore mem_unsigned.
  - rdata = 0 when mem_en=0, the access is a store, or either error flag is set.
- Same-cycle ordering: a load in the cycle after a store to the same word sees the new data. No same-edge bypass is needed; the pipeline never issues a store and a load together.
- Write-log:
  - At each edge, wlog_valid <= commit.
  - When commit is set, wlog_addr <= BASE_ADDR + (index<<2) and wlog_data <= merged word.
  - Otherwise wlog_addr and wlog_data hold their values.
- Reset:
  - reset low immediately clears every array word, wlog_valid, wlog_addr and wlog_data to 0, independent of clk.
  - While reset is low, no commit occurs; rdata therefore reads 0.
  - A store presented on the edge where reset deasserts is not committed if reset is still low at that edge.
- The block holds no internal pipeline state beyond the array and the write-log registers. The stall/flush of the M stage is handled by the surrounding pipeline registers.

Decomposition:
- Shared package cpu_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - DM byte-lane constants.
  - The default DEPTH_WORDS value.
- One combinational sub-module, dm_load_ext: word in, addr[1:0], size and unsigned flag in; extended rdata out. Reused by any later bridge/MMIO load path.

Test Plan:
- Reset pulse, then sw 32'h12345678 @0x10 → next cycle wlog_valid=1, wlog_addr=0x10, wlog_data=0x12345678; following lw @0x10 gives rdata=0x12345678.
- After the above, sb 0xAB @0x13 → word becomes 0xAB345678; lb @0x13 gives 0xFFFFFFAB; lbu @0x13 gives 0x000000AB.
- sh 0x8001 @0x12 → word becomes 0x80015678; lh @0x12 gives 0xFFFF8001; lhu @0x12 gives 0x00008001; lh @0x10 gives 0x00005678.
- sw @0x11 and sh @0x13 → align_err=1, word @0x10 unchanged, wlog_valid stays 0.
- With DEPTH_WORDS=1024: sw @0x1000 → range_err=1, no commit; lw @0x1000 gives rdata=0; lw @0xFFC works normally.
- Drive reset low between clock edges mid-test → rdata for lw @0x10 is 0 and wlog_valid=0 before the next edge. After release, sb commits normally with the other bytes of the word reading 0.
